// File: rtl/nfc_cmd_scheduler_if.sv
// Handshake bundle between the host, the command scheduler and the NAND
// flash controller. The scheduler connects through the master modport and
// the surrounding environment (host plus controller) through the slave one.
interface nfc_cmd_scheduler_if #(
    parameter int CommandWidth = 3,
    parameter int AddressWidth = 16,
    parameter int Depth        = 4
);
    localparam int CountWidth = $clog2(Depth) + 1;

    // host enqueue side
    logic                    host_valid;
    logic                    host_ready;
    logic [CommandWidth-1:0] host_cmd;
    logic [AddressWidth-1:0] host_addr;

    // controller side
    logic [CommandWidth-1:0] nfc_cmd;
    logic [AddressWidth-1:0] RWA;
    logic                    nfc_start;
    logic                    nfc_done;
    logic                    command_error;
    logic                    buf_owner;

    // completion / status reporting
    logic                    cmd_done;
    logic                    cmd_err;
    logic                    cmd_timeout;
    logic                    reject;
    logic [CountWidth-1:0]   queue_count;
    logic                    busy;

    modport master (
        input  host_valid, host_cmd, host_addr, nfc_done, command_error,
        output host_ready, nfc_cmd, RWA, nfc_start, buf_owner,
               cmd_done, cmd_err, cmd_timeout, reject, queue_count, busy
    );

    modport slave (
        output host_valid, host_cmd, host_addr, nfc_done, command_error,
        input  host_ready, nfc_cmd, RWA, nfc_start, buf_owner,
               cmd_done, cmd_err, cmd_timeout, reject, queue_count, busy
    );
endinterface

// File: rtl/nfc_cmd_scheduler.sv
// NAND flash command scheduler: queues host command/address pairs in a
// small FIFO and issues them one at a time to the flash controller,
// arbitrating page-buffer ownership and reporting completion, error and
// timeout per command. The executing command stays at the FIFO head until
// it completes, so queue_count includes it.
module nfc_cmd_scheduler #(
    parameter int CommandWidth  = 3,
    parameter int AddressWidth  = 16,
    parameter int Depth         = 4,
    parameter int TimeoutCycles = 4096
) (
    input logic                 clk,
    input logic                 Reset,
    nfc_cmd_scheduler_if.master bus
);
    localparam int PtrWidth   = $clog2(Depth);
    localparam int CountWidth = PtrWidth + 1;
    localparam int TimerWidth = $clog2(TimeoutCycles);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CommandWidth-1:0] CMD_RESET   = CommandWidth'(1);
    localparam logic [CommandWidth-1:0] CMD_READ    = CommandWidth'(2);
    localparam logic [CommandWidth-1:0] CMD_PROGRAM = CommandWidth'(3);
    localparam logic [CommandWidth-1:0] CMD_ERASE   = CommandWidth'(4);
    localparam logic [CommandWidth-1:0] CMD_READ_ID = CommandWidth'(5);

    localparam logic [CountWidth-1:0] COUNT_FULL = CountWidth'(Depth);
    localparam logic [TimerWidth-1:0] TIMER_LAST = TimerWidth'(TimeoutCycles - 1);

    // FIFO storage and bookkeeping
    logic [CommandWidth-1:0] fifo_cmd  [Depth];
    logic [AddressWidth-1:0] fifo_addr [Depth];
    logic [PtrWidth-1:0]     wr_ptr;
    logic [PtrWidth-1:0]     rd_ptr;
    logic [CountWidth-1:0]   count;
    logic [CountWidth-1:0]   count_next;

    // sequencer state
    logic [1:0]              state;
    logic [TimerWidth-1:0]   timer;
    logic                    err_flag;

    // registered outputs
    logic                    host_ready_q;
    logic                    reject_q;
    logic [CommandWidth-1:0] nfc_cmd_q;
    logic [AddressWidth-1:0] rwa_q;
    logic                    nfc_start_q;
    logic                    buf_owner_q;
    logic                    cmd_done_q;
    logic                    cmd_err_q;
    logic                    cmd_timeout_q;

    logic                    push;
    logic                    push_ok;
    logic                    pop;

    function automatic logic code_valid(input logic [CommandWidth-1:0] c);
        return (c == CMD_RESET) || (c == CMD_READ) || (c == CMD_PROGRAM) ||
               (c == CMD_ERASE) || (c == CMD_READ_ID);
    endfunction

    // only page transfers hand the page buffer to the controller
    function automatic logic needs_buffer(input logic [CommandWidth-1:0] c);
        return (c == CMD_READ) || (c == CMD_PROGRAM);
    endfunction

    assign push    = bus.host_valid && host_ready_q;
    assign push_ok = push && code_valid(bus.host_cmd);
    assign pop     = (state == S_DONE);

    // occupancy after this cycle's push/pop; simultaneous push and pop cancel
    always_comb begin
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + CountWidth'(1);
            2'b01:   count_next = count - CountWidth'(1);
            default: count_next = count;
        endcase
    end

    // FIFO payload storage; contents are don't-care once pointers are flushed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_cmd[wr_ptr]  <= bus.host_cmd;
            fifo_addr[wr_ptr] <= bus.host_addr;
        end
    end

    // pointers, occupancy, ready and reject bookkeeping
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            host_ready_q <= 1'b1;
            reject_q     <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrWidth'(1);
            end
            count        <= count_next;
            host_ready_q <= (count_next < COUNT_FULL);
            reject_q     <= push && !code_valid(bus.host_cmd);
        end
    end

    // command sequencer: issue head, wait for controller, report, pop
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state         <= S_IDLE;
            timer         <= '0;
            err_flag      <= 1'b0;
            nfc_cmd_q     <= '0;
            rwa_q         <= '0;
            nfc_start_q   <= 1'b0;
            buf_owner_q   <= 1'b0;
            cmd_done_q    <= 1'b0;
            cmd_err_q     <= 1'b0;
            cmd_timeout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // outputs are loaded on entry so they are valid during ISSUE
                    if (count != '0) begin
                        state       <= S_ISSUE;
                        nfc_cmd_q   <= fifo_cmd[rd_ptr];
                        rwa_q       <= fifo_addr[rd_ptr];
                        nfc_start_q <= 1'b1;
                        buf_owner_q <= needs_buffer(fifo_cmd[rd_ptr]);
                    end
                end
                S_ISSUE: begin
                    nfc_start_q <= 1'b0;
                    timer       <= '0;
                    err_flag    <= 1'b0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.nfc_done) begin
                        state         <= S_DONE;
                        cmd_done_q    <= 1'b1;
                        cmd_err_q     <= err_flag || bus.command_error;
                        cmd_timeout_q <= 1'b0;
                    end else if (timer == TIMER_LAST) begin
                        state         <= S_DONE;
                        cmd_done_q    <= 1'b1;
                        cmd_err_q     <= 1'b1;
                        cmd_timeout_q <= 1'b1;
                    end else begin
                        timer <= timer + TimerWidth'(1);
                        if (bus.command_error) begin
                            err_flag <= 1'b1;
                        end
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    cmd_done_q    <= 1'b0;
                    cmd_err_q     <= 1'b0;
                    cmd_timeout_q <= 1'b0;
                    buf_owner_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.host_ready  = host_ready_q;
    assign bus.reject      = reject_q;
    assign bus.nfc_cmd     = nfc_cmd_q;
    assign bus.RWA         = rwa_q;
    assign bus.nfc_start   = nfc_start_q;
    assign bus.buf_owner   = buf_owner_q;
    assign bus.cmd_done    = cmd_done_q;
    assign bus.cmd_err     = cmd_err_q;
    assign bus.cmd_timeout = cmd_timeout_q;
    assign bus.queue_count = count;
    assign bus.busy        = (state != S_IDLE) || (count != '0);

endmodule

// File: tb/tb_nfc_cmd_scheduler.sv
// Bench for nfc_cmd_scheduler: directed stimulus pushes expected issue and
// completion records into a queue; a monitor compares them whenever the
// scheduler starts or completes a command.
module tb_nfc_cmd_scheduler;
    logic clk;
    logic Reset;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  cmd;
        logic [15:0] addr;
        logic        owner;
        logic        err;
        logic        tmo;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    nfc_cmd_scheduler_if #(.CommandWidth(3), .AddressWidth(16), .Depth(4)) bus ();

    nfc_cmd_scheduler #(
        .CommandWidth (3),
        .AddressWidth (16),
        .Depth        (4),
        .TimeoutCycles(16)
    ) dut (
        .clk  (clk),
        .Reset(Reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_cmd(input logic [2:0] c, input logic [15:0] a,
                              input logic owner, input logic err, input logic tmo);
        exp_t e;
        e.cmd = c; e.addr = a; e.owner = owner; e.err = err; e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    task automatic push_one(input logic [2:0] c, input logic [15:0] a);
        bus.host_valid = 1'b1;
        bus.host_cmd   = c;
        bus.host_addr  = a;
        tick();
        bus.host_valid = 1'b0;
    endtask

    task automatic pulse_done();
        bus.nfc_done = 1'b1;
        tick();
        bus.nfc_done = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.nfc_start && n < 40);
        check("start_seen", bus.nfc_start, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_host_ready"},  bus.host_ready, 1);
        check({tag, "_nfc_start"},   bus.nfc_start, 0);
        check({tag, "_cmd_done"},    bus.cmd_done, 0);
        check({tag, "_cmd_err"},     bus.cmd_err, 0);
        check({tag, "_cmd_timeout"}, bus.cmd_timeout, 0);
        check({tag, "_reject"},      bus.reject, 0);
        check({tag, "_buf_owner"},   bus.buf_owner, 0);
        check({tag, "_busy"},        bus.busy, 0);
        check({tag, "_nfc_cmd"},     bus.nfc_cmd, 0);
        check({tag, "_rwa"},         bus.RWA, 0);
        check({tag, "_queue_count"}, bus.queue_count, 0);
    endtask

    // monitor: compare issued and completed commands against the scoreboard
    always @(negedge clk) begin
        if (Reset) begin
            if (bus.nfc_start) begin
                if (exp_q.size() == 0) begin
                    check("start_unexpected", bus.nfc_start, 0);
                end else begin
                    check("issue_cmd",   bus.nfc_cmd,   exp_q[0].cmd);
                    check("issue_addr",  bus.RWA,       exp_q[0].addr);
                    check("issue_owner", bus.buf_owner, exp_q[0].owner);
                end
            end
            if (bus.cmd_done) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", bus.cmd_done, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_err",  bus.cmd_err,     mon_e.err);
                    check("done_tmo",  bus.cmd_timeout, mon_e.tmo);
                    check("done_cmd",  bus.nfc_cmd,     mon_e.cmd);
                    check("done_addr", bus.RWA,         mon_e.addr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [2:0] bad_codes [3];
        bad_codes[0] = 3'b110;
        bad_codes[1] = 3'b111;
        bad_codes[2] = 3'b000;

        Reset             = 1'b0;
        bus.host_valid    = 1'b0;
        bus.host_cmd      = '0;
        bus.host_addr     = '0;
        bus.nfc_done      = 1'b0;
        bus.command_error = 1'b0;
        tick();
        tick();
        check_reset_values("rst");
        Reset = 1'b1;
        tick();

        // single read page with normal completion
        expect_cmd(3'b010, 16'h1234, 1'b1, 1'b0, 1'b0);
        push_one(3'b010, 16'h1234);
        check("t1_count", bus.queue_count, 1);
        wait_start(n);
        check("t1_issue_latency", n, 1);
        tick();
        check("t1_start_pulse", bus.nfc_start, 0);
        check("t1_owner_wait", bus.buf_owner, 1);
        repeat (9) tick();
        pulse_done();
        check("t1_cmd_done", bus.cmd_done, 1);
        check("t1_cmd_err", bus.cmd_err, 0);
        tick();
        check("t1_owner_after", bus.buf_owner, 0);
        check("t1_done_clear", bus.cmd_done, 0);
        check("t1_count_after", bus.queue_count, 0);

        // four erases fill the FIFO while the controller is stalled
        for (int i = 0; i < 4; i++) begin
            expect_cmd(3'b100, 16'hA000 + 16'(i), 1'b0, 1'b0, 1'b0);
            bus.host_valid = 1'b1;
            bus.host_cmd   = 3'b100;
            bus.host_addr  = 16'hA000 + 16'(i);
            tick();
        end
        bus.host_valid = 1'b0;
        check("t2_count_full", bus.queue_count, 4);
        check("t2_ready_full", bus.host_ready, 0);
        bus.host_valid = 1'b1;
        bus.host_cmd   = 3'b100;
        bus.host_addr  = 16'h5555;
        tick();
        tick();
        bus.host_valid = 1'b0;
        check("t2_count_held", bus.queue_count, 4);
        check("t2_ready_held", bus.host_ready, 0);
        pulse_done();
        for (int i = 0; i < 3; i++) begin
            wait_start(n);
            check("t2_reissue_latency", n, 2);
            tick();
            tick();
            pulse_done();
        end
        tick();
        check("t2_count_empty", bus.queue_count, 0);
        check("t2_ready_empty", bus.host_ready, 1);

        // invalid codes are dropped with a reject pulse
        foreach (bad_codes[i]) begin
            push_one(bad_codes[i], 16'hDEAD);
            check("t3_reject", bus.reject, 1);
            check("t3_count", bus.queue_count, 0);
            tick();
            check("t3_reject_clear", bus.reject, 0);
        end
        repeat (3) tick();
        check("t3_busy", bus.busy, 0);

        // error then done five cycles later
        expect_cmd(3'b011, 16'hBEEF, 1'b1, 1'b1, 1'b0);
        push_one(3'b011, 16'hBEEF);
        wait_start(n);
        tick();
        tick();
        bus.command_error = 1'b1;
        tick();
        bus.command_error = 1'b0;
        repeat (4) tick();
        pulse_done();
        tick();

        // error and done in the same cycle
        expect_cmd(3'b101, 16'h00A5, 1'b0, 1'b1, 1'b0);
        push_one(3'b101, 16'h00A5);
        wait_start(n);
        repeat (3) tick();
        bus.command_error = 1'b1;
        bus.nfc_done      = 1'b1;
        tick();
        bus.command_error = 1'b0;
        bus.nfc_done      = 1'b0;
        tick();

        // controller strobes while idle must not leak into the next command
        bus.command_error = 1'b1;
        bus.nfc_done      = 1'b1;
        tick();
        bus.command_error = 1'b0;
        bus.nfc_done      = 1'b0;
        check("t4_idle_strobe_busy", bus.busy, 0);
        expect_cmd(3'b001, 16'h0300, 1'b0, 1'b0, 1'b0);
        push_one(3'b001, 16'h0300);
        wait_start(n);
        repeat (3) tick();
        pulse_done();
        tick();

        // timeout: no nfc_done at all
        expect_cmd(3'b001, 16'h0042, 1'b0, 1'b1, 1'b1);
        push_one(3'b001, 16'h0042);
        wait_start(n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.cmd_done && n < 40);
        check("t5_timeout_latency", n, 17);
        tick();
        pulse_done();
        check("t5_late_done_ignored", bus.cmd_done, 0);
        tick();
        check("t5_busy_after", bus.busy, 0);

        // reset mid-WAIT with three entries queued
        for (int i = 0; i < 3; i++) begin
            expect_cmd(3'b010, 16'hB000 + 16'(i), 1'b1, 1'b0, 1'b0);
            bus.host_valid = 1'b1;
            bus.host_cmd   = 3'b010;
            bus.host_addr  = 16'hB000 + 16'(i);
            tick();
        end
        bus.host_valid = 1'b0;
        check("t6_count", bus.queue_count, 3);
        tick();
        check("t6_owner_wait", bus.buf_owner, 1);
        Reset = 1'b0;
        #1;
        check_reset_values("t6");
        exp_q.delete();
        tick();
        tick();
        Reset = 1'b1;
        tick();
        check("t6_no_done", bus.cmd_done, 0);
        check("t6_count_flushed", bus.queue_count, 0);
        expect_cmd(3'b011, 16'h7777, 1'b1, 1'b0, 1'b0);
        push_one(3'b011, 16'h7777);
        wait_start(n);
        check("t6_issue_latency", n, 1);
        repeat (3) tick();
        pulse_done();
        tick();
        tick();
        check("all_completed", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
